store_merge_unit: RTL and testbench
===================================

// Module: store_merge_unit
// PURPOSE
//  Write-side partner of the CPU load path. Executes sw/sh/sb as a multicycle memory transaction.
//  sh/sb do read-modify-write: read the aligned word, merge the byte/halfword lane, write the word back.
//  Sits between the control FSM (start/done) and the word-wide memory port.
//  Flags misaligned stores so the control FSM can raise an exception.
// PARAMETERS
//  MEM_LAT   1   memory read latency in cycles, legal 1..4: mem_rdata valid MEM_LAT cycles after mem_addr
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  start      in   1   request strobe; sampled only in IDLE
//  store_op   in   2   00=sw, 01=sh, 10=sb, 11=illegal
//  addr       in   32  byte address (ALUOut)
//  wdata      in   32  store data (reg B); sh uses [15:0], sb uses [7:0]
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle completion pulse
//  misalign   out  1   one-cycle pulse, coincident with done, on an alignment fault
//  mem_addr   out  32  word-aligned address {addr[31:2],2'b00}
//  mem_we     out  1   memory write strobe, high for exactly one cycle per store
//  mem_wdata  out  32  word to write
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; busy, done, misalign, mem_we = 0; mem_addr, mem_wdata = 0.
//  - Lanes are little-endian: addr[1:0]=k selects bits [8k+7:8k]; a halfword uses lanes {addr[1],0}.
//  - Accept: in IDLE with start=1 at edge k, latch store_op, addr, wdata and load mem_addr.
//    All outputs are registered. A start asserted while busy is ignored, not queued.
//  - FSM: IDLE, READ, WRITE, FIN, ERR.
//    - IDLE to ERR: sw with addr[1:0]!=0, sh with addr[0]=1, or store_op=11.
//    - IDLE to WRITE: sw aligned; mem_wdata=wdata.
//    - IDLE to READ: sh/sb aligned. Counter runs MEM_LAT cycles.
//      On the last READ cycle, capture mem_rdata, replace the target lane(s) with wdata, then go to WRITE.
//    - WRITE: mem_we=1 for this cycle only, then FIN.
//    - FIN: done=1 for one cycle, then IDLE.
//    - ERR: done=1 for one cycle; misalign=1 unless store_op=11; no memory write; then IDLE.
//  - Latency from accept edge k:
//    - sw: mem_we in cycle k+1, done in k+2.
//    - sh/sb: mem_we in k+MEM_LAT+1, done in k+MEM_LAT+2.
//    - error: done in k+1.
//  - mem_addr holds its value from accept until the next accept; mem_we is never high outside WRITE.
//  - Reset mid-transaction aborts it with no partial write; the first start after reset release is accepted normally.
//  - Back-to-back: a start during the FIN cycle is ignored; a start in the cycle after done is accepted.
// CONFIGURATION
//  STORE_BYTE_LANES_EN defined:
//    - adds output mem_be[3:0] (reset 4'b0000), valid only while mem_we=1.
//    - sh/sb skip READ and go IDLE to WRITE, so all stores take sw latency.
//    - mem_wdata holds wdata replicated in the target lanes: sb={4{wdata[7:0]}}, sh={2{wdata[15:0]}}.
//    - mem_be: sw=1111, sh=0011 or 1100, sb=one-hot lane.
//  Not defined:
//    - no mem_be port; sh/sb use the read-modify-write path above.
// TESTING
//  1 sw addr=0x40 wdata=0xDEADBEEF -> mem_we only in k+1, mem_addr=0x40, mem_wdata=0xDEADBEEF; done in k+2.
//  2 sb addr=0x41 wdata=0x000000AB, mem_rdata=0x11223344 -> write 0x1122AB44 at 0x40; done in k+MEM_LAT+2.
//  3 sh addr=0x42 wdata=0x0000CAFE, mem_rdata=0x11223344 -> write 0xCAFE3344; with STORE_BYTE_LANES_EN: mem_be=1100, write in k+1.
//  4 sh addr=0x43 and sw addr=0x42 -> misalign=1 and done=1 in k+1; mem_we never asserted. op=11 -> done only.
//  5 reset=0 during READ of sb -> busy=0 and mem_we=0 at once, no write; next sw completes per test 1.
//  6 start held high for 10 cycles during sh -> exactly one transaction, one mem_we; a new one is accepted after done.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store path for sw/sh/sb: aligned sw writes directly, sh/sb do read-modify-write on the aligned word.
// Optional macro STORE_BYTE_LANES_EN adds mem_be and lets sh/sb write directly with byte enables.
module store_merge_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
`ifdef STORE_BYTE_LANES_EN
  output logic [3:0]  mem_be,
`endif
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;
  localparam logic [1:0]  OP_SW = 2'b00;
  localparam logic [1:0]  OP_SH = 2'b01;
  localparam logic [1:0]  OP_SB = 2'b10;
  localparam logic [1:0]  OP_IL = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_FIN, S_ERR} state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_misalign;
  logic [31:0] r_mem_addr;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;
  logic        w_err;

  // Alignment faults and the illegal opcode all divert to ERR
  assign w_err = (store_op == OP_IL) ||
                 ((store_op == OP_SW) && (addr[1:0] != 2'b00)) ||
                 ((store_op == OP_SH) && addr[0]);

`ifdef STORE_BYTE_LANES_EN
  logic [3:0]  r_mem_be;
  logic [3:0]  w_be;
  logic [31:0] w_rep;

  always_comb begin
    w_be  = 4'b1111;
    w_rep = wdata;
    if (store_op == OP_SH) begin
      w_be  = addr[1] ? 4'b1100 : 4'b0011;
      w_rep = {2{wdata[15:0]}};
    end else if (store_op == OP_SB) begin
      w_be  = 4'(4'b0001 << addr[1:0]);
      w_rep = {4{wdata[7:0]}};
    end
  end

  assign mem_be = r_mem_be;
`else
  logic [1:0]       r_op;
  logic [1:0]       r_lane;
  logic [15:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_merged;

  // Overlay the target byte/halfword lane onto the word read back from memory
  always_comb begin
    w_merged = mem_rdata;
    if (r_op == OP_SB)
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'h0;
`ifdef STORE_BYTE_LANES_EN
      r_mem_be    <= 4'b0000;
`else
      r_op        <= OP_SW;
      r_lane      <= 2'b00;
      r_wdata     <= 16'h0;
      r_cnt       <= '0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_mem_we   <= 1'b0;
`ifdef STORE_BYTE_LANES_EN
      r_mem_be   <= 4'b0000;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_mem_addr <= {addr[31:2], 2'b00};
`ifndef STORE_BYTE_LANES_EN
            r_op       <= store_op;
            r_lane     <= addr[1:0];
            r_wdata    <= wdata[15:0];
`endif
            if (w_err) begin
              r_state    <= S_ERR;
              r_done     <= 1'b1;
              r_misalign <= (store_op != OP_IL);
            end else if (store_op == OP_SW) begin
              r_state     <= S_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= wdata;
`ifdef STORE_BYTE_LANES_EN
              r_mem_be    <= 4'b1111;
`endif
            end else begin
`ifdef STORE_BYTE_LANES_EN
              r_state     <= S_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_rep;
              r_mem_be    <= w_be;
`else
              r_state     <= S_READ;
              r_cnt       <= CNT_W'(MEM_LAT - 1);
`endif
            end
          end
        end
        S_READ: begin
`ifndef STORE_BYTE_LANES_EN
          if (r_cnt == '0) begin
            r_state     <= S_WRITE;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_merged;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
`else
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
`endif
        end
        S_WRITE: begin
          r_state <= S_FIN;
          r_done  <= 1'b1;
        end
        S_FIN, S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign misalign  = r_misalign;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit: driver queues expected writes/dones, monitor pops on DUT events.
module tb_store_merge_unit;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_op;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, misalign, mem_we;
  logic [31:0] mem_addr, mem_wdata;
`ifdef STORE_BYTE_LANES_EN
  logic [3:0]  mem_be;
`endif

  store_merge_unit #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .store_op(store_op),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .misalign(misalign), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata),
`ifdef STORE_BYTE_LANES_EN
    .mem_be(mem_be),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; int c; } wr_t;
  typedef struct { logic mis; int c; } dn_t;
  wr_t q_wr[$];
  dn_t q_dn[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mem_we) begin
        if (q_wr.size() == 0) check("unexpected_write", 32'(mem_we), 32'h0);
        else begin
          wr_t e;
          e = q_wr.pop_front();
          check("wr_addr", mem_addr, e.a);
          check("wr_data", mem_wdata, e.d);
          check("wr_cycle", 32'(cyc), 32'(e.c));
`ifdef STORE_BYTE_LANES_EN
          check("wr_be", 32'(mem_be), 32'(e.be));
`endif
        end
      end
      if (done) begin
        if (q_dn.size() == 0) check("unexpected_done", 32'(done), 32'h0);
        else begin
          dn_t e;
          e = q_dn.pop_front();
          check("done_misalign", 32'(misalign), 32'(e.mis));
          check("done_cycle", 32'(cyc), 32'(e.c));
        end
      end else begin
        check("misalign_without_done", 32'(misalign), 32'h0);
      end
    end
  end

  // k0 is the cycle count sampled just after the accept edge
  task automatic push_exp(input int k0, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] d_rmw, input logic [31:0] d_rep,
                          input logic [3:0] be, input logic is_err, input logic mis);
    int lw;
    logic [31:0] d;
    if (is_err) begin
      q_dn.push_back('{mis, k0});
    end else begin
`ifdef STORE_BYTE_LANES_EN
      lw = 1; d = d_rep;
`else
      lw = (op == 2'b00) ? 1 : int'(LAT) + 1; d = d_rmw;
`endif
      q_wr.push_back('{{a[31:2], 2'b00}, d, be, k0 + lw - 1});
      q_dn.push_back('{1'b0, k0 + lw});
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd);
    store_op = op; addr = a; wdata = d; mem_rdata = rd; start = 1'b1;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] rd, input logic [31:0] d_rmw, input logic [31:0] d_rep,
                     input logic [3:0] be, input logic is_err, input logic mis);
    int k0;
    wait_idle();
    drive(op, a, d, rd);
    @(posedge clk); #1;
    start = 1'b0;
    k0 = cyc;
    push_exp(k0, op, a, d_rmw, d_rep, be, is_err, mis);
    check("busy_after_accept", 32'(busy), 32'h1);
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    int k0;
    int i;
    reset = 1'b0; start = 1'b0; store_op = 2'b00; addr = '0; wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
`ifdef STORE_BYTE_LANES_EN
    check("rst_be", 32'(mem_be), 32'h0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // Directed stores: op, addr, wdata, mem_rdata, rmw result, replicated data, be, err, misalign
    run(2'b00, 32'h40,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    run(2'b10, 32'h41,  32'h000000AB, 32'h11223344, 32'h1122AB44, 32'hABABABAB, 4'b0010, 1'b0, 1'b0);
    run(2'b01, 32'h42,  32'h0000CAFE, 32'h11223344, 32'hCAFE3344, 32'hCAFECAFE, 4'b1100, 1'b0, 1'b0);
    run(2'b10, 32'h103, 32'h00000055, 32'hAABBCCDD, 32'h55BBCCDD, 32'h55555555, 4'b1000, 1'b0, 1'b0);
    run(2'b01, 32'h200, 32'h12349876, 32'hAABBCCDD, 32'hAABB9876, 32'h98769876, 4'b0011, 1'b0, 1'b0);
    run(2'b00, 32'h44,  32'h01234567, 32'h0,        32'h01234567, 32'h01234567, 4'b1111, 1'b0, 1'b0);
    run(2'b01, 32'h43,  32'h0000CAFE, 32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 1'b1);
    run(2'b00, 32'h42,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 1'b1);
    run(2'b00, 32'h41,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 1'b1);
    run(2'b11, 32'h40,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        4'b0000, 1'b1, 1'b0);
    check("err_addr_held", mem_addr, 32'h40);

    // Reset during the read phase of sb aborts with no write
    wait_idle();
    drive(2'b10, 32'h41, 32'h000000AB, 32'h11223344);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
`ifndef STORE_BYTE_LANES_EN
    check("abort_busy_before", 32'(busy), 32'h1);
    check("abort_no_we_yet", 32'(mem_we), 32'h0);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_we", 32'(mem_we), 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
`else
    q_wr.push_back('{32'h40, 32'hABABABAB, 4'b0010, cyc});
    q_dn.push_back('{1'b0, cyc + 1});
`endif
    run(2'b00, 32'h40, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);

    // start held high through an sh: only one accept while busy; a start after done is taken
    wait_idle();
    drive(2'b01, 32'h42, 32'h0000CAFE, 32'h11223344);
    @(posedge clk); #1;
    k0 = cyc;
    push_exp(k0, 2'b01, 32'h42, 32'hCAFE3344, 32'hCAFECAFE, 4'b1100, 1'b0, 1'b0);
    wdata = 32'hFFFF0000; addr = 32'h80;
    i = 0;
    @(negedge clk);
    while (!done && i < 10) begin
      @(negedge clk);
      i++;
    end
    check("hold_done_seen", 32'(done), 32'h1);
    drive(2'b00, 32'h48, 32'h600DF00D, 32'h0);
    @(negedge clk);
    check("hold_idle_after_fin", 32'(busy), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    k0 = cyc;
    push_exp(k0, 2'b00, 32'h48, 32'h600DF00D, 32'h600DF00D, 4'b1111, 1'b0, 1'b0);
    check("hold_reaccept_busy", 32'(busy), 32'h1);
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);

    check("pending_writes", 32'(q_wr.size()), 32'h0);
    check("pending_dones", 32'(q_dn.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
